// File: rtl/mf_cen_nco_bank_if.sv
// Configuration handshake bundle for mf_cen_nco_bank: valid/ready plus channel, increment, phase.
// The master drives the request; the slave (the bank) returns ready.
interface mf_cen_nco_bank_if #(
    parameter int CH_W  = 3,
    parameter int ACC_W = 32
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch;
    logic [ACC_W-1:0] cfg_inc;
    logic [ACC_W-1:0] cfg_phase;

    modport master (output cfg_valid, cfg_ch, cfg_inc, cfg_phase, input cfg_ready);
    modport slave  (input cfg_valid, cfg_ch, cfg_inc, cfg_phase, output cfg_ready);
endinterface

// File: rtl/mf_cen_nco_bank.sv
// Bank of phase-accumulator clock-enable generators; optional toggle outclk under MF_CEN_OUTCLK_EN.
// Latency: cen is the registered carry of acc+inc; config takes effect at the handshake edge.
// Backpressure: cfg_ready is low while settling; requests are only accepted in the locked state.
module mf_cen_nco_bank #(
    parameter int NUM_CH   = 5,
    parameter int ACC_W    = 32,
    parameter int CH_W     = 3,
    parameter int LOCK_CNT = 4
) (
    input  logic              refclk,
    input  logic              rst,
    mf_cen_nco_bank_if.slave  cfg,
    output logic [NUM_CH-1:0] cen,
    output logic              locked
`ifdef MF_CEN_OUTCLK_EN
    ,
    output logic [NUM_CH-1:0] outclk
`endif
);

    typedef enum logic {SETTLE, LOCKED} state_t;

    localparam logic [CH_W:0] NUM_CH_L   = (CH_W+1)'(NUM_CH);
    localparam logic [7:0]    LOCK_CNT_L = 8'(LOCK_CNT);

    state_t            state_q, state_nxt;
    logic              cfg_ready_q;
    logic [ACC_W-1:0]  acc_q   [NUM_CH];
    logic [ACC_W-1:0]  inc_q   [NUM_CH];
    logic [ACC_W-1:0]  acc_sum [NUM_CH];
    logic [7:0]        cnt_q   [NUM_CH];
    logic [NUM_CH-1:0] carry;
    logic [NUM_CH-1:0] sat;
    logic [NUM_CH-1:0] hs_sel;
    logic              hs;
    logic              hs_ch_ok;

    assign cfg.cfg_ready = cfg_ready_q;

    always_comb begin
        hs       = cfg.cfg_valid && cfg_ready_q;
        hs_ch_ok = ({1'b0, cfg.cfg_ch} < NUM_CH_L);
        carry    = '0;
        sat      = '0;
        hs_sel   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            {carry[i], acc_sum[i]} = {1'b0, acc_q[i]} + {1'b0, inc_q[i]};
            hs_sel[i] = hs && hs_ch_ok && (cfg.cfg_ch == CH_W'(i));
            // A disabled channel never pulses, so it must not hold off lock.
            sat[i]    = (inc_q[i] == '0) || (cnt_q[i] == LOCK_CNT_L);
        end
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            SETTLE:  if (&sat)    state_nxt = LOCKED;
            LOCKED:  if (|hs_sel) state_nxt = SETTLE;
            default: state_nxt = SETTLE;
        endcase
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q     <= SETTLE;
            locked      <= 1'b0;
            cfg_ready_q <= 1'b0;
        end else begin
            state_q     <= state_nxt;
            locked      <= (state_nxt == LOCKED);
            cfg_ready_q <= (state_nxt == LOCKED);
        end
    end

    always_ff @(posedge refclk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (rst) begin
                acc_q[i] <= '0;
                inc_q[i] <= '0;
                cen[i]   <= 1'b0;
            end else if (hs_sel[i]) begin
                acc_q[i] <= cfg.cfg_phase;
                inc_q[i] <= cfg.cfg_inc;
                cen[i]   <= 1'b0;
            end else begin
                acc_q[i] <= acc_sum[i];
                cen[i]   <= carry[i];
            end

            // Counting the carry (not the registered cen) lets lock rise on the edge after the last pulse.
            if (rst || (|hs_sel)) begin
                cnt_q[i] <= '0;
            end else if (carry[i] && (cnt_q[i] != LOCK_CNT_L)) begin
                cnt_q[i] <= cnt_q[i] + 8'd1;
            end
        end
    end

`ifdef MF_CEN_OUTCLK_EN
    always_ff @(posedge refclk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (rst || hs_sel[i]) begin
                outclk[i] <= 1'b0;
            end else if (cen[i]) begin
                outclk[i] <= ~outclk[i];
            end
        end
    end
`endif

endmodule
